// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store front end of the 2048x32 data memory:
// geometry, access-size encodings, FSM states and the request legality rule.
package mips_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  // Misaligned halves/words and the reserved size encoding are rejected.
  function automatic logic bad_request(input logic [1:0] size, input logic [1:0] offset);
    return (size == SZ_ILL) ||
           (size == SZ_HALF && offset[0]) ||
           (size == SZ_WORD && offset != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response channel of mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: load extraction with sign/zero extension and
// sub-word store merge into the previously read word.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [DATA_W-1:0] rd_word,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_data;

  always_comb begin
    byte_sel = rd_word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Replicate the new lane across the word, then keep only the addressed bytes.
  always_comb begin
    case (size)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << {offset, 3'b000};
        lane_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_mask = offset[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata;
      end
    endcase
    store_word = (rd_word & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: accepts one CPU request at a time, drives the memory
// write/read ports, and does read-modify-write for byte and half stores.
module mem_access_unit #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    cpu,
  output logic [ADDR_W-1:0]   mem_a,
  output logic [DATA_W-1:0]   mem_d,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_dpra,
  input  logic [DATA_W-1:0]   mem_dpo
);

  import mips_mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        off_q, off_d;
  size_e             size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_bad;
  logic              write_cycle;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  mem_lane_align u_align (
    .rd_word    (mem_dpo),
    .offset     (off_q),
    .size       (size_q),
    .is_signed  (sgn_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (merged_word)
  );

  assign req_bad = bad_request(cpu.req_size, cpu.req_addr[1:0]);

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch of the case infers a latch.
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          waddr_d = cpu.req_addr[ADDR_W+1:2];
          off_d   = cpu.req_addr[1:0];
          size_d  = size_e'(cpu.req_size);
          sgn_d   = cpu.req_signed;
          we_d    = cpu.req_we;
          wdata_d = cpu.req_wdata;
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = load_data;
          state_d = RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = RESP;
        end else begin
          // The merged word reuses the store-data register for the WRITE cycle.
          wdata_d = merged_word;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write strobe comes from registered state only, so reset kills it at once.
  assign write_cycle = (state_q == WRITE) ||
                       (state_q == ACCESS && we_q && size_q == SZ_WORD);

  assign mem_we   = write_cycle;
  assign mem_a    = waddr_q;
  assign mem_dpra = waddr_q;
  assign mem_d    = write_cycle ? wdata_q : '0;

  assign cpu.req_ready  = (state_q == IDLE);
  assign cpu.resp_valid = (state_q == RESP);
  assign cpu.resp_rdata = rdata_q;
  assign cpu.resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 2048x32 memory.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] mem_a, mem_dpra;
  logic [31:0] mem_d, mem_dpo;
  logic        mem_we;

  logic [31:0] mem     [2048];
  logic [31:0] ref_mem [2048];

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   resp_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (bus),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_dpra (mem_dpra),
    .mem_dpo  (mem_dpo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
  assign mem_dpo = mem[mem_dpra];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] off,
                                             logic [1:0] sz, logic sgn);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (sz)
      2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(logic [31:0] w, logic [31:0] wd,
                                              logic [1:0] off, logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: r[off*8 +: 8] = wd[7:0];
      2'b01: r[off[1]*16 +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic model_err(logic [1:0] sz, logic [1:0] off);
    return (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) wr_cnt++;
      else if (mem_d !== 32'h0) check("mem_d_idle", mem_d, 32'h0);
      if (bus.resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          check("spurious_resp", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_rdata", bus.resp_rdata, mon_e.rdata);
          check("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
          check("resp_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Starts and ends on a falling edge; leaves req_valid high.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [12:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int          lat;
    int          guard;
    logic [10:0] wa;
    logic [31:0] merged;
    exp_t        e;
    wa  = addr[12:2];
    lat = exp_err ? 0 : ((we && sz != 2'b10) ? 2 : 1);
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    e.rdata = (we || exp_err) ? 32'h0 : exp_rd;
    e.err   = exp_err;
    e.cyc   = cyc + 1 + lat;
    sb.push_back(e);
    merged = model_merge(ref_mem[wa], wd, addr[1:0], sz);
    @(negedge clk);
    check("ready_low", 32'(bus.req_ready), 0);
    if (!exp_err && we) begin
      if (sz == 2'b10) begin
        check("word_we", 32'(mem_we), 1);
        check("word_a", 32'(mem_a), 32'(wa));
        check("word_d", mem_d, wd);
      end else begin
        check("rmw_read_we", 32'(mem_we), 0);
        check("rmw_dpra", 32'(mem_dpra), 32'(wa));
        @(negedge clk);
        check("rmw_we", 32'(mem_we), 1);
        check("rmw_a", 32'(mem_a), 32'(wa));
        check("rmw_d", mem_d, merged);
      end
      ref_mem[wa] = merged;
    end else if (!exp_err) begin
      check("load_dpra", 32'(mem_dpra), 32'(wa));
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic sgn,
                     input logic [12:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int w0;
    w0 = wr_cnt;
    do_req(we, sz, sgn, addr, wd, exp_rd, exp_err);
    bus.req_valid = 1'b0;
    wait_done();
    check("we_count", wr_cnt - w0, (we && !exp_err) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved, wd, exp;
    logic [10:0] wa;
    logic [1:0]  off, sz;
    logic        we, sgn, err;
    int          w0, r0;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_err", 32'(bus.resp_err), 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_a", 32'(mem_a), 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_mem_dpra", 32'(mem_dpra), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the intended use.
    txn(1, 2'b10, 0, 13'h010, 32'hDEADBEEF, 0, 0);
    check("mem_word", mem[4], 32'hDEADBEEF);
    txn(0, 2'b10, 0, 13'h010, 0, 32'hDEADBEEF, 0);
    txn(1, 2'b00, 0, 13'h011, 32'h000000AA, 0, 0);
    check("mem_byte", mem[4], 32'hDEADAAEF);
    txn(0, 2'b00, 1, 13'h013, 0, 32'hFFFFFFDE, 0);
    txn(0, 2'b00, 0, 13'h013, 0, 32'h000000DE, 0);
    txn(0, 2'b01, 1, 13'h012, 0, 32'hFFFFDEAD, 0);
    txn(0, 2'b01, 0, 13'h010, 0, 32'h0000AAEF, 0);
    txn(0, 2'b00, 1, 13'h011, 0, 32'hFFFFFFAA, 0);

    // Illegal and misaligned requests.
    txn(0, 2'b10, 0, 13'h006, 0, 0, 1);
    txn(1, 2'b01, 0, 13'h011, 32'h1111, 0, 1);
    txn(0, 2'b11, 0, 13'h000, 0, 0, 1);
    txn(1, 2'b11, 0, 13'h010, 32'h22222222, 0, 1);
    check("mem_after_err", mem[4], 32'hDEADAAEF);

    txn(1, 2'b01, 0, 13'h012, 32'h00001234, 0, 0);
    check("mem_half", mem[4], 32'h1234AAEF);

    // Top word of the memory.
    txn(1, 2'b10, 0, 13'h1FFC, 32'hCAFEF00D, 0, 0);
    txn(0, 2'b00, 0, 13'h1FFF, 0, 32'h000000CA, 0);
    txn(0, 2'b01, 1, 13'h1FFE, 0, 32'hFFFFCAFE, 0);
    check("mem_top", mem[2047], 32'hCAFEF00D);

    // Back-to-back loads with req_valid held high.
    w0 = wr_cnt;
    r0 = resp_cnt;
    do_req(0, 2'b10, 0, 13'h010, 0, 32'h1234AAEF, 0);
    do_req(0, 2'b00, 1, 13'h011, 0, 32'hFFFFFFAA, 0);
    do_req(0, 2'b01, 0, 13'h012, 0, 32'h00001234, 0);
    bus.req_valid = 1'b0;
    wait_done();
    check("b2b_writes", wr_cnt - w0, 0);
    check("b2b_resps", resp_cnt - r0, 3);

    // Reset while the RMW write strobe is asserted.
    saved = ref_mem[4];
    do_req(1, 2'b00, 0, 13'h011, 32'h00000055, 0, 0);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 0);
    check("abort_d", mem_d, 0);
    check("abort_ready", 32'(bus.req_ready), 1);
    check("abort_resp", 32'(bus.resp_valid), 0);
    sb.delete();
    ref_mem[4] = saved;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_mem", mem[4], 32'h1234AAEF);
    r0 = resp_cnt;
    repeat (4) @(negedge clk);
    check("abort_no_resp", resp_cnt - r0, 0);
    check("abort_ready_after", 32'(bus.req_ready), 1);
    txn(0, 2'b10, 0, 13'h010, 0, 32'h1234AAEF, 0);

    // Randomised mix over a small window of words.
    for (int i = 8; i < 16; i++) begin
      wd = $urandom;
      txn(1, 2'b10, 0, {11'(i), 2'b00}, wd, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      wa  = 11'($urandom_range(8, 15));
      off = 2'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      wd  = $urandom;
      err = model_err(sz, off);
      exp = model_load(ref_mem[wa], off, sz, sgn);
      txn(we, sz, sgn, {wa, off}, wd, exp, err);
    end
    for (int i = 8; i < 16; i++) check("rand_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the 2048×32 data memory wrapper. It accepts CPU load/store requests with byte addresses and byte/half/word size, and drives the memory's write port (a/d/we) and read port (dpra/dpo). Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data through a single-cycle response pulse.

## Interface
- ADDR_W, 11: word-address width of the memory.
- DATA_W, 32: data width; the design supports only 32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend loads; ignored for stores.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request; valid with resp_valid.
- mem_a  out  ADDR_W  write word address.
- mem_d  out  DATA_W  write data.
- mem_we  out  1  write enable.
- mem_dpra  out  ADDR_W  read word address.
- mem_dpo  in  DATA_W  combinational read data from memory.

## Operation
- A request is accepted on the clock edge where req_valid && req_ready. On acceptance the unit registers the word address (req_addr[ADDR_W+1:2]), byte offset, size, signed, we and wdata.
- Addressing is little-endian.
  - Byte offset k selects bits [8k+7:8k].
  - Half offset 0 selects [15:0]; half offset 2 selects [31:16].
- Error conditions: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - FSM goes IDLE→RESP with resp_err=1.
  - No mem_we pulse is issued.
- FSM states:
  - IDLE → ACCESS on acceptance (or → RESP on error).
  - Load, ACCESS: mem_dpra = word address. At the edge, mem_dpo is extracted/extended into resp_rdata. Go to RESP.
  - Word store, ACCESS: mem_we=1, mem_a = word address, mem_d = wdata. Go to RESP.
  - Byte/half store, ACCESS: mem_we=0, mem_dpra = word address. At the edge, old word merged with the new lane is registered. Go to WRITE.
  - WRITE: mem_we=1, mem_a = word address, mem_d = merged word. Go to RESP.
  - RESP: resp_valid=1. Go to IDLE.
- mem_a and mem_dpra always show the registered word address. mem_d = 0 whenever mem_we=0.
- mem_we and req_ready decode from the state register only (no combinational path from req_* to mem_*).
- Exactly one mem_we cycle per legal store; zero for loads and errors.

## Timing
- Acceptance edge E0.
  - Loads and word stores: resp_valid high between E1 and E2.
  - Sub-word stores: write at E2, resp_valid between E2 and E3.
  - Errors: resp_valid between E0 and E1.
- req_ready returns high in the cycle after RESP. Maximum throughput is one request every 3 cycles (4 for RMW).
- Reset (rst_n low, at any time):
  - State goes to IDLE immediately; all registers clear.
  - req_ready=1; resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_d, mem_dpra = 0.
- Reset during ACCESS/WRITE aborts the request. mem_we drops asynchronously, no partial write occurs, and no response is produced.
- The request inputs are ignored while req_ready=0.

## Structure
- Shared package mips_mem_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum {IDLE, ACCESS, WRITE, RESP}.
  - ADDR_W/DATA_W constants.
- One combinational sub-module, mem_lane_align, provides:
  - load extraction with sign/zero extension (word, offset, size, signed → rdata);
  - store merge (old word, wdata, offset, size → new word).
- The FSM and registers stay in mem_access_unit.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x010 → one mem_we cycle with mem_a=4, mem_d=0xDEADBEEF. Word load from 0x010 → resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store 0xAA to 0x011 over 0xDEADBEEF → read cycle (mem_we=0), then mem_we with mem_d=0xDEADAAEF. resp_valid lands 2 edges after acceptance.
- Byte load at 0x013: signed → 0xFFFFFFDE; unsigned → 0x000000DE. Half load at 0x012 signed → 0xFFFFDEAD.
- Misaligned cases: word load at 0x006, half store at 0x011, size=11 → resp_err=1, resp_rdata=0, no mem_we, resp_valid one cycle after acceptance.
- Back-to-back: req_valid held high with 3 loads → req_ready low during ACCESS/RESP, all 3 responses in order, no request dropped or duplicated.
- rst_n pulsed low during WRITE of a byte store → mem_we falls immediately, memory word unchanged, no resp_valid, req_ready=1 after release.
